// File: rtl/ysyx_24100005_lsu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ysyx_24100005_lsu                                            |
// | Description : Multi-cycle load/store unit. Valid/ready handshakes toward   |
// |               the EXU, the data memory and the WBU; byte-lane alignment,   |
// |               sign/zero extension, early fault detection, resp timeout.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ysyx_24100005_lsu #(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_load,
  input  logic              in_store,
  input  logic [2:0]        in_funct3,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [XLEN-1:0]   in_wdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_wen,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [XLEN-1:0]   mem_req_wdata,
  output logic [XLEN/8-1:0] mem_req_wmask,
  input  logic              mem_resp_valid,
  input  logic [XLEN-1:0]   mem_resp_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_rdata,
  output logic              out_err
);

  localparam int c_NB   = XLEN / 8;
  localparam int c_OFFW = $clog2(c_NB);
  localparam int c_CNTW = $clog2(TIMEOUT);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_REQ  = 2'd1;
  localparam logic [1:0] c_WAIT = 2'd2;
  localparam logic [1:0] c_RESP = 2'd3;

  logic [1:0]        r_state;
  logic [1:0]        w_next;
  logic              r_load;
  logic [2:0]        r_funct3;
  logic [c_OFFW-1:0] r_off;
  logic [ADDR_W-1:0] r_addr;
  logic [XLEN-1:0]   r_wdata;
  logic [c_NB-1:0]   r_wmask;
  logic [XLEN-1:0]   r_rdata;
  logic              r_err;
  logic [c_CNTW-1:0] r_cnt;

  logic              w_accept;
  logic              w_noop;
  logic              w_illegal;
  logic              w_misalign;
  logic              w_fault;
  logic              w_timeout;
  logic [c_NB-1:0]   w_mask_base;
  logic [XLEN-1:0]   w_lane;
  logic [XLEN-1:0]   w_tmp;
  logic [6:0]        w_shamt;
  logic [XLEN-1:0]   w_load_ext;

  assign w_accept  = in_valid && (r_state == c_IDLE);
  assign w_noop    = !in_load && !in_store;
  assign w_timeout = (r_cnt == c_CNTW'(TIMEOUT - 1));
  assign w_fault   = (in_load && in_store) || w_illegal || w_misalign;

  // Classify the incoming request: illegal encodings, misalignment, store lane strobes.
  always_comb begin
    w_illegal   = 1'b0;
    w_misalign  = 1'b0;
    w_mask_base = '0;
    if (in_load)
      w_illegal = (in_funct3 == 3'b111) ||
                  ((XLEN == 32) && ((in_funct3 == 3'b011) || (in_funct3 == 3'b110)));
    if (in_store)
      w_illegal = w_illegal || in_funct3[2] || ((XLEN == 32) && (in_funct3 == 3'b011));
    case (in_funct3[1:0])
      2'd0: begin w_misalign = 1'b0;            w_mask_base = c_NB'(1);   end
      2'd1: begin w_misalign = in_addr[0];      w_mask_base = c_NB'(3);   end
      2'd2: begin w_misalign = |in_addr[1:0];   w_mask_base = c_NB'(15);  end
      default: begin w_misalign = |in_addr[2:0]; w_mask_base = {c_NB{1'b1}}; end
    endcase
    if (w_noop)
      w_misalign = 1'b0;
  end

  // Pick the addressed lane out of the read word and extend it to XLEN.
  always_comb begin
    w_lane = mem_resp_rdata >> {r_off, 3'b000};
    case (r_funct3[1:0])
      2'd0:    w_shamt = 7'(XLEN - 8);
      2'd1:    w_shamt = 7'(XLEN - 16);
      2'd2:    w_shamt = 7'(XLEN - 32);
      default: w_shamt = '0;
    endcase
    w_tmp = w_lane << w_shamt;
    if (r_funct3[2])
      w_load_ext = w_tmp >> w_shamt;
    else
      w_load_ext = $signed(w_tmp) >>> w_shamt;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst)
      r_state <= c_IDLE;
    else
      r_state <= w_next;
  end

  // Next-state logic; faulty and no-op requests bypass memory entirely.
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE: if (in_valid) w_next = (w_noop || w_fault) ? c_RESP : c_REQ;
      c_REQ:  if (mem_req_ready) w_next = c_WAIT;
      c_WAIT: if (mem_resp_valid || w_timeout) w_next = c_RESP;
      default: if (out_ready) w_next = c_IDLE;
    endcase
  end

  // Outputs decoded from state and the captured request/result registers.
  always_comb begin
    in_ready      = (r_state == c_IDLE);
    mem_req_valid = (r_state == c_REQ);
    out_valid     = (r_state == c_RESP);
    mem_req_wen   = !r_load;
    mem_req_addr  = r_addr;
    mem_req_wdata = r_wdata;
    mem_req_wmask = r_wmask;
    out_rdata     = r_rdata;
    out_err       = r_err;
  end

  // Request capture, wait-cycle counting and result latching.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_load   <= 1'b0;
      r_funct3 <= '0;
      r_off    <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_wmask  <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      if (w_accept) begin
        r_load   <= in_load;
        r_funct3 <= in_funct3;
        r_off    <= in_addr[c_OFFW-1:0];
        r_addr   <= {in_addr[ADDR_W-1:c_OFFW], {c_OFFW{1'b0}}};
        r_wdata  <= in_store ? (in_wdata << {in_addr[c_OFFW-1:0], 3'b000}) : '0;
        r_wmask  <= in_store ? (w_mask_base << in_addr[c_OFFW-1:0]) : '0;
        r_rdata  <= '0;
        r_err    <= w_fault;
      end
      if (r_state == c_WAIT) begin
        r_cnt <= r_cnt + c_CNTW'(1);
        // A response arriving on the last allowed cycle still beats the timeout.
        if (mem_resp_valid) begin
          r_rdata <= r_load ? w_load_ext : '0;
          r_err   <= 1'b0;
        end else if (w_timeout) begin
          r_rdata <= '0;
          r_err   <= 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_24100005_lsu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_ysyx_24100005_lsu                                         |
// | Description : Self-checking bench for the load/store unit: directed cases  |
// |               plus randomized transactions against a reference model, and  |
// |               a second RV64 instance for doubleword/word-unsigned accesses.|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_ysyx_24100005_lsu;

  localparam int TO32 = 12;
  localparam int TO64 = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // RV32 instance signals
  logic        in_valid = 0, in_load = 0, in_store = 0;
  logic [2:0]  in_funct3 = 0;
  logic [31:0] in_addr = 0, in_wdata = 0;
  logic        in_ready;
  logic        mem_req_valid, mem_req_wen;
  logic        mem_req_ready = 0;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_resp_valid = 0;
  logic [31:0] mem_resp_rdata = 0;
  logic        out_valid, out_err;
  logic        out_ready = 0;
  logic [31:0] out_rdata;

  // RV64 instance signals
  logic        d_in_valid = 0, d_in_load = 0, d_in_store = 0;
  logic [2:0]  d_in_funct3 = 0;
  logic [31:0] d_in_addr = 0;
  logic [63:0] d_in_wdata = 0;
  logic        d_in_ready;
  logic        d_mem_req_valid, d_mem_req_wen;
  logic        d_mem_req_ready = 0;
  logic [31:0] d_mem_req_addr;
  logic [63:0] d_mem_req_wdata;
  logic [7:0]  d_mem_req_wmask;
  logic        d_mem_resp_valid = 0;
  logic [63:0] d_mem_resp_rdata = 0;
  logic        d_out_valid, d_out_err;
  logic        d_out_ready = 0;
  logic [63:0] d_out_rdata;

  ysyx_24100005_lsu #(.XLEN(32), .ADDR_W(32), .TIMEOUT(TO32)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_load(in_load), .in_store(in_store),
    .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_wen(mem_req_wen),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata), .out_err(out_err)
  );

  ysyx_24100005_lsu #(.XLEN(64), .ADDR_W(32), .TIMEOUT(TO64)) u_dut64 (
    .clk(clk), .rst(rst),
    .in_valid(d_in_valid), .in_ready(d_in_ready), .in_load(d_in_load), .in_store(d_in_store),
    .in_funct3(d_in_funct3), .in_addr(d_in_addr), .in_wdata(d_in_wdata),
    .mem_req_valid(d_mem_req_valid), .mem_req_ready(d_mem_req_ready), .mem_req_wen(d_mem_req_wen),
    .mem_req_addr(d_mem_req_addr), .mem_req_wdata(d_mem_req_wdata), .mem_req_wmask(d_mem_req_wmask),
    .mem_resp_valid(d_mem_resp_valid), .mem_resp_rdata(d_mem_resp_rdata),
    .out_valid(d_out_valid), .out_ready(d_out_ready), .out_rdata(d_out_rdata), .out_err(d_out_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference load result: take the addressed bytes, then sign- or zero-extend.
  function automatic logic [31:0] load_model(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] resp);
    longint bits;
    longint v;
    bits = 8 * (1 << f3[1:0]);
    v = 0;
    v = resp >> (8 * off);
    v = v % (longint'(1) << bits);
    if (!f3[2] && v >= (longint'(1) << (bits - 1)))
      v = v - (longint'(1) << bits);
    return v[31:0];
  endfunction

  // One RV32 transaction with chosen request stall, response delay (>=TO32 means
  // no response at all) and WBU back-pressure; every cycle's outputs are checked.
  task automatic run_op(input bit ld, input bit st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] resp, input int stall, input int delay,
                        input int ostall);
    int bytes, off, n;
    bit legal, early, tmo;
    logic [31:0] exp_rd, exp_wd;
    logic [3:0]  exp_mask;
    logic        exp_err;
    bytes = 1 << f3[1:0];
    off   = int'(addr[1:0]);
    if (ld && st)  legal = 0;
    else if (ld)   legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) && (int'(addr[2:0]) % bytes == 0);
    else if (st)   legal = (f3 inside {3'd0, 3'd1, 3'd2}) && (int'(addr[2:0]) % bytes == 0);
    else           legal = 1;
    early    = !(ld ^ st) || !legal;
    tmo      = !early && (delay >= TO32);
    exp_err  = (ld && st) || ((ld ^ st) && !legal) || tmo;
    exp_rd   = (!early && !tmo && ld) ? load_model(f3, addr[1:0], resp) : 32'h0;
    exp_mask = st ? 4'(((1 << bytes) - 1) << off) : 4'h0;
    exp_wd   = wdata << (8 * off);

    chk("in_ready_idle", in_ready, 1);
    in_valid = 1; in_load = ld; in_store = st; in_funct3 = f3; in_addr = addr; in_wdata = wdata;
    step();
    in_valid = 0; in_addr = $urandom; in_wdata = $urandom; in_funct3 = 3'($urandom);

    if (!early) begin
      for (int i = 0; i <= stall; i++) begin
        chk("req_valid", mem_req_valid, 1);
        chk("req_addr", mem_req_addr, addr & 32'hFFFF_FFFC);
        chk("req_wen", mem_req_wen, st);
        chk("req_wmask", mem_req_wmask, exp_mask);
        if (st) chk("req_wdata", mem_req_wdata, exp_wd);
        chk("in_ready_busy", in_ready, 0);
        mem_req_ready  = (i == stall);
        mem_resp_valid = (i < stall) ? 1'($urandom_range(0, 1)) : 1'b0;
        mem_resp_rdata = $urandom;
        step();
      end
      mem_req_ready = 0; mem_resp_valid = 0;
      n = tmo ? TO32 : delay + 1;
      for (int i = 0; i < n; i++) begin
        chk("wait_req_valid", mem_req_valid, 0);
        chk("wait_out_valid", out_valid, 0);
        mem_resp_valid = !tmo && (i == delay);
        mem_resp_rdata = (i == delay) ? resp : $urandom;
        step();
      end
      mem_resp_valid = 0;
    end else begin
      chk("early_req_valid", mem_req_valid, 0);
    end

    for (int i = 0; i <= ostall; i++) begin
      chk("out_valid", out_valid, 1);
      chk("out_rdata", out_rdata, exp_rd);
      chk("out_err", out_err, exp_err);
      out_ready      = (i == ostall);
      mem_resp_valid = (i < ostall) ? 1'($urandom_range(0, 1)) : 1'b0;
      mem_resp_rdata = $urandom;
      step();
    end
    out_ready = 0; mem_resp_valid = 0;
    chk("out_valid_done", out_valid, 0);
    chk("in_ready_done", in_ready, 1);
  endtask

  // One RV64 transaction, no stalls, expectations supplied by the caller.
  task automatic op64(input bit ld, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [63:0] wdata, input logic [63:0] resp,
                      input logic [7:0] exp_mask, input logic [63:0] exp_wd,
                      input logic [63:0] exp_rd, input bit exp_err);
    d_in_valid = 1; d_in_load = ld; d_in_store = !ld; d_in_funct3 = f3;
    d_in_addr = addr; d_in_wdata = wdata;
    step();
    d_in_valid = 0;
    if (!exp_err) begin
      chk("d_req_valid", d_mem_req_valid, 1);
      chk("d_req_addr", d_mem_req_addr, addr & 32'hFFFF_FFF8);
      chk("d_req_wmask", d_mem_req_wmask, exp_mask);
      if (!ld) chk("d_req_wdata", d_mem_req_wdata, exp_wd);
      d_mem_req_ready = 1;
      step();
      d_mem_req_ready = 0; d_mem_resp_valid = 1; d_mem_resp_rdata = resp;
      step();
      d_mem_resp_valid = 0;
    end else begin
      chk("d_early_req_valid", d_mem_req_valid, 0);
    end
    chk("d_out_valid", d_out_valid, 1);
    chk("d_out_rdata", d_out_rdata, exp_rd);
    chk("d_out_err", d_out_err, exp_err);
    d_out_ready = 1;
    step();
    d_out_ready = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ld, st;
    logic [2:0] f3;
    logic [31:0] a;
    int sel, dly;

    rst = 1;
    repeat (2) step();
    rst = 0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_rdata", out_rdata, 0);
    chk("rst_out_err", out_err, 0);

    // Directed cases
    run_op(1, 0, 3'b000, 32'h8000_0003, 32'h0, 32'h80FF_1234, 0, 0, 0);      // lb
    run_op(1, 0, 3'b100, 32'h8000_0003, 32'h0, 32'h80FF_1234, 0, 0, 0);      // lbu
    run_op(0, 1, 3'b001, 32'h8000_0002, 32'h0000_ABCD, 32'h0, 0, 0, 0);      // sh
    run_op(1, 0, 3'b010, 32'h8000_0001, 32'h0, 32'h0, 0, 0, 0);              // misaligned lw
    run_op(1, 0, 3'b001, 32'h8000_0002, 32'h0, 32'h8123_4567, 3, 1, 0);      // req stalled 3
    run_op(1, 0, 3'b010, 32'h8000_0004, 32'h0, 32'h1234_5678, 0, TO32, 2);   // timeout, held out
    run_op(1, 0, 3'b101, 32'h8000_0002, 32'h0, 32'hF00D_8001, 0, TO32-1, 0); // resp wins at limit
    run_op(0, 0, 3'b000, 32'h8000_0000, 32'h0, 32'h0, 0, 0, 1);              // no-op
    run_op(1, 1, 3'b010, 32'h8000_0000, 32'h0, 32'h0, 0, 0, 0);              // load&store
    run_op(1, 0, 3'b011, 32'h8000_0000, 32'h0, 32'h0, 0, 0, 0);              // ld on RV32
    run_op(0, 1, 3'b100, 32'h8000_0000, 32'h0, 32'h0, 0, 0, 0);              // illegal store

    // Reset while waiting for a response; the late response must be ignored.
    in_valid = 1; in_load = 1; in_store = 0; in_funct3 = 3'b010; in_addr = 32'h8000_0000;
    step();
    in_valid = 0; mem_req_ready = 1;
    step();
    mem_req_ready = 0; rst = 1;
    step();
    rst = 0;
    chk("rstw_in_ready", in_ready, 1);
    chk("rstw_out_valid", out_valid, 0);
    mem_resp_valid = 1; mem_resp_rdata = 32'hDEAD_BEEF;
    step();
    mem_resp_valid = 0;
    chk("rstw_late_out_valid", out_valid, 0);
    chk("rstw_late_in_ready", in_ready, 1);
    chk("rstw_req_valid", mem_req_valid, 0);

    // Randomized transactions
    for (int k = 0; k < 160; k++) begin
      sel = $urandom_range(0, 19);
      ld  = (sel < 9) || (sel == 19);
      st  = (sel >= 9 && sel < 18) || (sel == 19);
      f3  = 3'($urandom);
      a   = 32'h8000_0000 | ($urandom & 32'h0000_FFFF);
      if ($urandom_range(0, 9) < 7) a = a & ~((32'd1 << f3[1:0]) - 32'd1);
      dly = ($urandom_range(0, 9) == 0) ? TO32 : $urandom_range(0, 4);
      run_op(ld, st, f3, a, $urandom, $urandom, $urandom_range(0, 3), dly, $urandom_range(0, 2));
    end

    // RV64 instance
    op64(1, 3'b011, 32'h8000_0008, 64'h0, 64'hF000_0000_0000_0012,
         8'h00, 64'h0, 64'hF000_0000_0000_0012, 0);                               // ld
    op64(1, 3'b010, 32'h8000_0004, 64'h0, 64'h8000_0001_0000_0000,
         8'h00, 64'h0, 64'hFFFF_FFFF_8000_0001, 0);                               // lw
    op64(1, 3'b110, 32'h8000_0004, 64'h0, 64'h8000_0001_0000_0000,
         8'h00, 64'h0, 64'h0000_0000_8000_0001, 0);                               // lwu
    op64(1, 3'b000, 32'h8000_0007, 64'h0, 64'h8000_0000_0000_0000,
         8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_FF80, 0);                               // lb
    op64(0, 3'b011, 32'h8000_0010, 64'h1122_3344_5566_7788, 64'h0,
         8'hFF, 64'h1122_3344_5566_7788, 64'h0, 0);                               // sd
    op64(0, 3'b010, 32'h8000_0004, 64'h0000_0000_DEAD_BEEF, 64'h0,
         8'hF0, 64'hDEAD_BEEF_0000_0000, 64'h0, 0);                               // sw
    op64(1, 3'b011, 32'h8000_0004, 64'h0, 64'h0, 8'h00, 64'h0, 64'h0, 1);         // misaligned ld
    op64(1, 3'b111, 32'h8000_0000, 64'h0, 64'h0, 8'h00, 64'h0, 64'h0, 1);         // illegal load

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
